// File: rtl/ram_port_pkg.sv
// Shared types and limits for the RAM port master and its response buffer.
// Responses travel as {err, data}, with err as the MSB.
package ram_port_pkg;

  localparam int RSP_WIDTH = 16;
  localparam int PEND_MAX  = 2;

  typedef struct packed {
    logic                 err;
    logic [RSP_WIDTH-1:0] data;
  } ram_rsp_t;

endpackage

// File: rtl/rsp_skid_fifo.sv
// Two-entry in-order response buffer. An arriving entry bypasses straight to
// the output when the buffer is empty, and is stored only if it is not taken.
module rsp_skid_fifo
  import ram_port_pkg::*;
#(
  parameter type entry_t = ram_rsp_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_valid,
  input  entry_t push_data,
  input  logic   pop_ready,
  output logic   out_valid,
  output entry_t out_data,
  output logic   full,
  output logic   empty
);

  entry_t     mem_reg [2];
  logic       rd_ptr_reg;
  logic       rd_ptr_next;
  logic       wr_ptr_reg;
  logic       wr_ptr_next;
  logic [1:0] cnt_reg;
  logic [1:0] cnt_next;
  logic       enq;
  logic       deq;

  assign empty = (cnt_reg == 2'd0);
  assign full  = (cnt_reg == 2'd2);
  assign deq   = !empty && pop_ready;

  // Store only what is not consumed on the bypass path, and never overrun.
  assign enq = push_valid && !(empty && pop_ready) && !(full && !deq);

  assign out_valid = !empty || push_valid;

  always_comb begin
    out_data = '0;
    if (!empty) begin
      out_data = mem_reg[rd_ptr_reg];
    end else if (push_valid) begin
      out_data = push_data;
    end
  end

  always_comb begin
    cnt_next    = cnt_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    if (enq) begin
      wr_ptr_next = ~wr_ptr_reg;
    end
    if (deq) begin
      rd_ptr_next = ~rd_ptr_reg;
    end
    case ({enq, deq})
      2'b10:   cnt_next = cnt_reg + 2'd1;
      2'b01:   cnt_next = cnt_reg - 2'd1;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
    end else begin
      cnt_reg    <= cnt_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      for (int i = 0; i < 2; i++) begin
        if (enq && (wr_ptr_reg == 1'(i))) begin
          mem_reg[i] <= push_data;
        end
      end
    end
  end

endmodule

// File: rtl/ram_port_master.sv
// Initiator for one port of a write-first block RAM: turns a request stream
// into RAM strobes and returns in-order responses with at most two pending.
module ram_port_master #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_wdata,
  input  logic [WIDTH-1:0]  ram_rdata
);
  import ram_port_pkg::*;

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] data;
  } rsp_t;

  logic [1:0] pend_reg;
  logic [1:0] pend_next;
  logic       inflight_reg;
  logic       inflight_next;
  logic       inflight_err_reg;
  logic       inflight_err_next;
  logic       accept;
  logic       in_range;
  logic       pop;
  logic       arr_valid;
  rsp_t       arr_rsp;
  rsp_t       head_rsp;
  logic       fifo_full;
  logic       fifo_empty;

  // Pending count covers the in-flight access plus buffered responses, so
  // ready depends on registered state only.
  assign req_ready = (pend_reg < 2'(PEND_MAX));
  assign in_range  = (req_addr < ADDR_W'(DEPTH));
  assign accept    = req_valid && req_ready;

  assign ram_en    = accept && in_range;
  assign ram_we    = ram_en && req_we;
  assign ram_addr  = req_addr;
  assign ram_wdata = req_wdata;

  assign pop = rsp_valid && rsp_ready;

  always_comb begin
    pend_next         = pend_reg;
    inflight_next     = accept;
    inflight_err_next = accept && !in_range;
    case ({accept, pop})
      2'b10:   pend_next = pend_reg + 2'd1;
      2'b01:   pend_next = pend_reg - 2'd1;
      default: pend_next = pend_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg         <= 2'd0;
      inflight_reg     <= 1'b0;
      inflight_err_reg <= 1'b0;
    end else begin
      pend_reg         <= pend_next;
      inflight_reg     <= inflight_next;
      inflight_err_reg <= inflight_err_next;
    end
  end

  // RAM output is only meaningful the cycle after an in-range issue.
  always_comb begin
    arr_valid    = inflight_reg;
    arr_rsp.err  = inflight_err_reg;
    arr_rsp.data = '0;
    if (inflight_reg && !inflight_err_reg) begin
      arr_rsp.data = ram_rdata;
    end
  end

  rsp_skid_fifo #(
    .entry_t (rsp_t)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (arr_valid),
    .push_data  (arr_rsp),
    .pop_ready  (rsp_ready),
    .out_valid  (rsp_valid),
    .out_data   (head_rsp),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign rsp_data = head_rsp.data;
  assign rsp_err  = head_rsp.err;

  // A full buffer implies two pending, so nothing can be arriving.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_full && arr_valid) && (fifo_empty || rsp_valid));

endmodule

// File: tb/tb_ram_port_master.sv
// Self-checking bench for ram_port_master with a write-first RAM model and a
// queue-based scoreboard of expected responses.
module tb_ram_port_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_port_master #(.WIDTH(16), .DEPTH(1024), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Write-first RAM, preloaded with 0x100+addr on the first clock.
  logic [15:0] ram_mem [0:1023];
  logic        ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= 16'(256 + i);
      ram_init <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) begin
        ram_mem[ram_addr[9:0]] <= ram_wdata;
        ram_rdata <= ram_wdata;
      end else begin
        ram_rdata <= ram_mem[ram_addr[9:0]];
      end
    end
  end

  // Reference model: memory contents are preload value unless written.
  typedef struct {
    logic        err;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q [$];
  logic [15:0] ref_wr [logic [31:0]];
  logic        hold_chk = 1'b0;
  logic [15:0] hold_data;
  logic        hold_err;

  // Sampled mid-cycle: inputs are settled and handshakes complete at the next posedge.
  always @(negedge clk) begin
    logic model_ready;
    logic exp_en;
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      hold_chk = 1'b0;
    end else begin
      model_ready = (exp_q.size() < 2);
      exp_en      = req_valid && model_ready && (req_addr < 32'd1024);
      n_cmp++;
      if (req_ready !== model_ready) begin
        n_bad++;
        $display("FAIL sb_req_ready: got %b want %b", req_ready, model_ready);
      end
      n_cmp++;
      if (rsp_valid !== (exp_q.size() > 0)) begin
        n_bad++;
        $display("FAIL sb_rsp_valid: got %b want %b", rsp_valid, exp_q.size() > 0);
      end
      n_cmp++;
      if (ram_en !== exp_en || ram_we !== (exp_en && req_we)) begin
        n_bad++;
        $display("FAIL sb_ram_en: got en=%b we=%b want en=%b we=%b", ram_en, ram_we, exp_en, exp_en && req_we);
      end
      if (exp_en) begin
        n_cmp++;
        if (ram_addr !== req_addr || ram_wdata !== req_wdata) begin
          n_bad++;
          $display("FAIL sb_ram_bus: got addr=%h wdata=%h want addr=%h wdata=%h", ram_addr, ram_wdata, req_addr, req_wdata);
        end
      end
      if (hold_chk) begin
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== hold_data || rsp_err !== hold_err) begin
          n_bad++;
          $display("FAIL sb_rsp_hold: got v=%b d=%h e=%b want v=1 d=%h e=%b", rsp_valid, rsp_data, rsp_err, hold_data, hold_err);
        end
      end
      if (exp_q.size() > 0) begin
        n_cmp++;
        if (rsp_data !== exp_q[0].data || rsp_err !== exp_q[0].err) begin
          n_bad++;
          $display("FAIL sb_rsp_data: got d=%h e=%b want d=%h e=%b", rsp_data, rsp_err, exp_q[0].data, exp_q[0].err);
        end
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) void'(exp_q.pop_front());
      end
      hold_chk  = (rsp_valid === 1'b1) && (rsp_ready !== 1'b1);
      hold_data = rsp_data;
      hold_err  = rsp_err;
      if (req_valid && model_ready) begin
        if (req_addr >= 32'd1024) begin
          e.err = 1'b1; e.data = 16'h0;
        end else if (req_we) begin
          e.err = 1'b0; e.data = req_wdata;
          ref_wr[req_addr] = req_wdata;
        end else begin
          e.err  = 1'b0;
          e.data = ref_wr.exists(req_addr) ? ref_wr[req_addr] : 16'(256 + req_addr);
        end
        exp_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [15:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || ram_en !== 1'b0 || ram_we !== 1'b0 ||
          rsp_data !== 16'h0 || rsp_err !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state: got rdy=%b rv=%b en=%b we=%b d=%h e=%b want 1 0 0 0 0000 0",
                 req_ready, rsp_valid, ram_en, ram_we, rsp_data, rsp_err);
      end
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || ram_en !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got rdy=%b rv=%b en=%b want 1 0 0", req_ready, rsp_valid, ram_en);
    end
    $display("reset: released, req_ready=%b", req_ready);
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      drive_req(1'b0, 32'(i), 16'h0);
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready);
      end
      if (i > 0) begin
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'(255 + i)) begin
          n_bad++;
          $display("FAIL b2b_data[%0d]: got v=%b d=%h want v=1 d=%h", i, rsp_valid, rsp_data, 16'(255 + i));
        end
      end
      $display("b2b: read addr %0d, rsp_data=%h", i, rsp_data);
    end
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h107) begin
      n_bad++;
      $display("FAIL b2b_last: got v=%b d=%h want v=1 d=0107", rsp_valid, rsp_data);
    end
    tick();
  endtask

  task automatic test_write_read();
    rsp_ready = 1'b1;
    tick();
    drive_req(1'b1, 32'd5, 16'hBEEF);
    @(negedge clk);
    n_cmp++;
    if (ram_en !== 1'b1 || ram_we !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_issue: got en=%b we=%b want 1 1", ram_en, ram_we);
    end
    tick();
    drive_req(1'b0, 32'd5, 16'h0);
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF || rsp_err !== 1'b0 || ram_en !== 1'b1 || ram_we !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_rsp: got v=%b d=%h e=%b en=%b we=%b want 1 beef 0 1 0", rsp_valid, rsp_data, rsp_err, ram_en, ram_we);
    end
    $display("write_read: write 5 rsp=%h", rsp_data);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF || ram_en !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_rsp: got v=%b d=%h en=%b want 1 beef 0", rsp_valid, rsp_data, ram_en);
    end
    $display("write_read: read 5 rsp=%h", rsp_data);
    tick();
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_idle: got rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    tick();
    drive_req(1'b0, 32'd1, 16'h0);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_first_ready: got %b want 1", req_ready);
    end
    tick();
    drive_req(1'b0, 32'd2, 16'h0);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_data !== 16'h101) begin
      n_bad++;
      $display("FAIL bp_second: got rdy=%b d=%h want 1 0101", req_ready, rsp_data);
    end
    tick();
    drive_req(1'b0, 32'd3, 16'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 16'h101) begin
        n_bad++;
        $display("FAIL bp_stall[%0d]: got rdy=%b v=%b d=%h want 0 1 0101", i, req_ready, rsp_valid, rsp_data);
      end
      $display("backpressure: stall cycle %0d rsp_data=%h", i, rsp_data);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0 || rsp_data !== 16'h101) begin
      n_bad++;
      $display("FAIL bp_pop1: got rdy=%b d=%h want 0 0101", req_ready, rsp_data);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_data !== 16'h102) begin
      n_bad++;
      $display("FAIL bp_pop2: got rdy=%b d=%h want 1 0102", req_ready, rsp_data);
    end
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h103) begin
      n_bad++;
      $display("FAIL bp_pop3: got v=%b d=%h want 1 0103", rsp_valid, rsp_data);
    end
    $display("backpressure: drained, last rsp_data=%h", rsp_data);
    tick();
  endtask

  task automatic test_out_of_range();
    rsp_ready = 1'b1;
    tick();
    drive_req(1'b0, 32'd0, 16'h0);
    @(negedge clk);
    n_cmp++;
    if (ram_en !== 1'b1) begin
      n_bad++;
      $display("FAIL oor_en0: got %b want 1", ram_en);
    end
    tick();
    drive_req(1'b0, 32'd1024, 16'h0);
    @(negedge clk);
    n_cmp++;
    if (ram_en !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 16'h100 || rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL oor_rsp0: got en=%b v=%b d=%h e=%b want 0 1 0100 0", ram_en, rsp_valid, rsp_data, rsp_err);
    end
    tick();
    drive_req(1'b0, 32'd1, 16'h0);
    @(negedge clk);
    n_cmp++;
    if (ram_en !== 1'b1 || rsp_valid !== 1'b1 || rsp_data !== 16'h0 || rsp_err !== 1'b1) begin
      n_bad++;
      $display("FAIL oor_rsp_err: got en=%b v=%b d=%h e=%b want 1 1 0000 1", ram_en, rsp_valid, rsp_data, rsp_err);
    end
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h101 || rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL oor_rsp1: got v=%b d=%h e=%b want 1 0101 0", rsp_valid, rsp_data, rsp_err);
    end
    $display("out_of_range: sequence done");
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    tick();
    drive_req(1'b0, 32'd2, 16'h0);
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rstmid_in_reset[%0d]: got rsp_valid=%b want 0", i, rsp_valid);
      end
      tick();
    end
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL rstmid_after[%0d]: got v=%b rdy=%b want 0 1", i, rsp_valid, req_ready);
      end
      tick();
    end
    $display("reset_mid: no stale response");
  endtask

  task automatic test_random();
    int sel;
    int k;
    for (int i = 0; i < 400; i++) begin
      tick();
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      req_addr = 32'd1024 + 32'($urandom_range(0, 3));
      else if (sel == 1) req_addr = $urandom | 32'h8000_0000;
      else               req_addr = 32'($urandom_range(0, 15));
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 1) == 1;
      req_wdata = 16'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      if (i % 50 == 0) $display("random: cycle %0d pending=%0d", i, exp_q.size());
    end
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      tick();
      k++;
    end
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL random_drain: got pending=%0d v=%b want 0 0", exp_q.size(), rsp_valid);
    end
    $display("random: drained after %0d cycles", k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 16'h0;
    rsp_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_write_read();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
